// File: rtl/cache_line_refill_if.sv
// Miss-side and bridge read-port signals of the cache line refill engine.
// The crit_valid/crit_data pair exists only when CRITICAL_WORD_FWD_EN is defined.
interface cache_line_refill_if;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_uncached;
    logic         miss_rdy;
    logic         cancel;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         line_valid;
    logic [31:0]  line_addr;
    logic [127:0] line_data;
    logic         proto_err;
`ifdef CRITICAL_WORD_FWD_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    // slave: the refill engine itself
    modport slave (
        input  miss_req, miss_addr, miss_uncached, cancel, rd_rdy, ret_valid, ret_last, ret_data,
        output miss_rdy, rd_req, rd_type, rd_addr, line_valid, line_addr, line_data, proto_err
`ifdef CRITICAL_WORD_FWD_EN
        , output crit_valid, crit_data
`endif
    );

    modport master (
        output miss_req, miss_addr, miss_uncached, cancel, rd_rdy, ret_valid, ret_last, ret_data,
        input  miss_rdy, rd_req, rd_type, rd_addr, line_valid, line_addr, line_data, proto_err
`ifdef CRITICAL_WORD_FWD_EN
        , input crit_valid, crit_data
`endif
    );
endinterface

// File: rtl/cache_line_refill.sv
// Refill engine: takes one cache miss, issues a burst or single-word bridge read, assembles the line.
// Optional macro CRITICAL_WORD_FWD_EN adds early forwarding of the missed word on crit_valid/crit_data.
//
//  state | meaning
//  IDLE  | ready for a miss (miss_rdy=1)
//  REQ   | rd_req raised, waiting for rd_rdy
//  RECV  | collecting return beats into the line buffer
//  DONE  | line_valid pulse, line held stable
//  DRAIN | cancelled after acceptance, swallowing beats up to ret_last
module cache_line_refill #(
    parameter int       LINE_WORDS    = 4,
    parameter logic [2:0] CACHED_TYPE   = 3'b100,
    parameter logic [2:0] UNCACHED_TYPE = 3'b010
) (
    input  logic                i_aclk,
    input  logic                i_areset,
    cache_line_refill_if.slave  io_refill
);
    localparam int                BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_REQ   = 5'b00010,
        S_RECV  = 5'b00100,
        S_DONE  = 5'b01000,
        S_DRAIN = 5'b10000
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [BEAT_W-1:0]           r_beat_cnt;
    logic [BEAT_W-1:0]           r_slot;
    logic                        r_uncached;
    logic [31:0]                 r_addr;
    logic [2:0]                  r_rd_type;
    logic [LINE_WORDS-1:0][31:0] r_words;
    logic                        r_proto_err;

    logic                        w_accept;
    logic                        w_beat;
    logic                        w_beat_err;
    logic [BEAT_W-1:0]           w_wr_idx;
    logic                        w_unused_addr;

    assign w_accept = (r_state == S_IDLE) & io_refill.miss_req;
    assign w_beat   = (r_state == S_RECV) & io_refill.ret_valid;
    assign w_wr_idx = r_uncached ? r_slot : r_beat_cnt;
    // A cached burst must end exactly on the final word; an uncached read is a single last beat.
    assign w_beat_err = r_uncached ? ((r_beat_cnt == '0) & ~io_refill.ret_last)
                                   : (io_refill.ret_last ^ (r_beat_cnt == LAST_BEAT));
    assign w_unused_addr = ^io_refill.miss_addr[1:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (io_refill.miss_req) w_next = S_REQ;
            end
            S_REQ: begin
                if (io_refill.cancel)      w_next = io_refill.rd_rdy ? S_DRAIN : S_IDLE;
                else if (io_refill.rd_rdy) w_next = S_RECV;
            end
            S_RECV: begin
                // A last beat coinciding with cancel already closes the burst: nothing left to drain.
                if (io_refill.cancel)
                    w_next = (io_refill.ret_valid & io_refill.ret_last) ? S_IDLE : S_DRAIN;
                else if (io_refill.ret_valid & io_refill.ret_last)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (io_refill.ret_valid & io_refill.ret_last) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef CRITICAL_WORD_FWD_EN
    logic        r_crit_valid;
    logic [31:0] r_crit_data;
    assign io_refill.crit_valid = r_crit_valid;
    assign io_refill.crit_data  = r_crit_data;
`endif

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_slot      <= '0;
            r_uncached  <= 1'b0;
            r_addr      <= '0;
            r_rd_type   <= '0;
            r_words     <= '0;
            r_proto_err <= 1'b0;
`ifdef CRITICAL_WORD_FWD_EN
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= io_refill.miss_uncached ? {io_refill.miss_addr[31:2], 2'b00}
                                                      : {io_refill.miss_addr[31:4], 4'b0000};
                r_rd_type  <= io_refill.miss_uncached ? UNCACHED_TYPE : CACHED_TYPE;
                r_uncached <= io_refill.miss_uncached;
                r_slot     <= io_refill.miss_addr[2 +: BEAT_W];
                r_beat_cnt <= '0;
            end
            if (w_beat) begin
                r_words[w_wr_idx] <= io_refill.ret_data;
                r_beat_cnt        <= r_beat_cnt + 1'b1;
                if (w_beat_err) r_proto_err <= 1'b1;
            end
`ifdef CRITICAL_WORD_FWD_EN
            r_crit_valid <= w_beat & ~r_uncached & ~io_refill.cancel & (r_beat_cnt == r_slot);
            if (w_beat & (r_beat_cnt == r_slot)) r_crit_data <= io_refill.ret_data;
`endif
        end
    end

    assign io_refill.miss_rdy   = (r_state == S_IDLE);
    assign io_refill.rd_req     = (r_state == S_REQ);
    assign io_refill.rd_type    = r_rd_type;
    assign io_refill.rd_addr    = r_addr;
    assign io_refill.line_valid = (r_state == S_DONE);
    assign io_refill.line_addr  = r_addr;
    assign io_refill.line_data  = r_words;
    assign io_refill.proto_err  = r_proto_err;
endmodule

// File: tb/tb_cache_line_refill.sv
// Self-checking bench for cache_line_refill: directed test-plan cases plus randomized fills
// compared against a transaction-level model of the line buffer and error flag.
module tb_cache_line_refill;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_line_refill_if bus ();
    cache_line_refill dut (.i_aclk(clk), .i_areset(rst), .io_refill(bus));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor
    int           lv_cnt = 0;
    int           lv_cyc = 0;
    logic [127:0] lv_data;
    logic [31:0]  lv_addr;
    always @(negedge clk) begin
        if (bus.line_valid === 1'b1) begin
            lv_cnt  <= lv_cnt + 1;
            lv_cyc  <= cyc;
            lv_data <= bus.line_data;
            lv_addr <= bus.line_addr;
        end
    end
`ifdef CRITICAL_WORD_FWD_EN
    int          crit_cnt = 0;
    int          crit_cyc = 0;
    logic [31:0] crit_data;
    always @(negedge clk) begin
        if (bus.crit_valid === 1'b1) begin
            crit_cnt  <= crit_cnt + 1;
            crit_cyc  <= cyc;
            crit_data <= bus.crit_data;
        end
    end
`endif

    // reference model: line words and sticky error, updated per delivered beat
    logic [31:0] m_words [4];
    bit          m_err;
    logic [31:0] bdata [8];
    int          bcyc [8];
    int          t0, t_last;
    logic        o_req, o_rdy_n1, o_rdy_n2;
    logic [31:0] o_rdaddr;
    logic [2:0]  o_rdtype;

    function automatic logic [127:0] m_line();
        return {m_words[3], m_words[2], m_words[1], m_words[0]};
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input bit unc);
        return unc ? (a & ~32'h3) : (a & ~32'hF);
    endfunction

    // drives one miss; final beat carries ret_last; cancel_after = beat index followed by a cancel cycle
    task automatic refill(input logic [31:0] addr, input bit unc, input int nbeats,
                          input int gap, input int rdy_wait, input int cancel_after);
        bit cancelled = 0;
        t0 = cyc;
        bus.miss_req = 1'b1; bus.miss_addr = addr; bus.miss_uncached = unc;
        @(negedge clk);
        bus.miss_req = 1'b0; bus.miss_addr = $urandom; bus.miss_uncached = 1'($urandom_range(0, 1));
        o_req = bus.rd_req; o_rdaddr = bus.rd_addr; o_rdtype = bus.rd_type;
        repeat (rdy_wait) @(negedge clk);
        bus.rd_rdy = 1'b1;
        @(negedge clk);
        bus.rd_rdy = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bit last;
            last = (i == nbeats - 1);
            bus.ret_valid = 1'b1; bus.ret_data = bdata[i]; bus.ret_last = last;
            bcyc[i] = cyc;
            if (!cancelled) begin
                m_words[unc ? int'(addr[3:2]) : i % 4] = bdata[i];
                if (unc) m_err |= (i == 0) && !last;
                else     m_err |= (last != (i % 4 == 3));
            end
            @(negedge clk);
            bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
            if (last) begin
                t_last = bcyc[i];
                o_rdy_n1 = bus.miss_rdy;
                @(negedge clk);
                o_rdy_n2 = bus.miss_rdy;
            end else begin
                if (i == cancel_after) begin
                    bus.cancel = 1'b1;
                    @(negedge clk);
                    bus.cancel = 1'b0;
                    cancelled = 1;
                end
                repeat (gap) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.miss_rdy !== 1'b1) begin errors++; $display("FAIL reset_miss_rdy got=%b exp=1", bus.miss_rdy); end
        checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", bus.rd_req); end
        checks++; if (bus.rd_type !== 3'b000) begin errors++; $display("FAIL reset_rd_type got=%b exp=000", bus.rd_type); end
        checks++; if (bus.rd_addr !== 32'h0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
        checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid got=%b exp=0", bus.line_valid); end
        checks++; if (bus.line_addr !== 32'h0) begin errors++; $display("FAIL reset_line_addr got=%h exp=0", bus.line_addr); end
        checks++; if (bus.line_data !== 128'h0) begin errors++; $display("FAIL reset_line_data got=%h exp=0", bus.line_data); end
        checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_words[i] = 32'h0;
        m_err = 0;
        @(negedge clk);
    endtask

    task automatic test_cached_fill();
        int lv0;
        lv0 = lv_cnt;
        for (int i = 0; i < 4; i++) bdata[i] = 32'hA0 + i;
        refill(32'h1C00_0014, 1'b0, 4, 0, 0, -1);
        checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL cached_rd_req got=%b exp=1", o_req); end
        checks++; if (o_rdaddr !== 32'h1C00_0010) begin errors++; $display("FAIL cached_rd_addr got=%h exp=1c000010", o_rdaddr); end
        checks++; if (o_rdtype !== 3'b100) begin errors++; $display("FAIL cached_rd_type got=%b exp=100", o_rdtype); end
        checks++; if (lv_cnt - lv0 != 1) begin errors++; $display("FAIL cached_lv_count got=%0d exp=1", lv_cnt - lv0); end
        checks++; if (lv_cyc - t0 != 6) begin errors++; $display("FAIL cached_lv_latency got=%0d exp=6", lv_cyc - t0); end
        checks++; if (lv_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL cached_line_data got=%h exp=000000a3000000a2000000a1000000a0", lv_data); end
        checks++; if (lv_addr !== 32'h1C00_0010) begin errors++; $display("FAIL cached_line_addr got=%h exp=1c000010", lv_addr); end
        checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL cached_proto_err got=%b exp=0", bus.proto_err); end
        checks++; if (o_rdy_n1 !== 1'b0 || o_rdy_n2 !== 1'b1) begin errors++; $display("FAIL cached_miss_rdy_timing got=%b%b exp=01", o_rdy_n1, o_rdy_n2); end
    endtask

    task automatic test_uncached();
        int lv0;
        lv0 = lv_cnt;
        bdata[0] = 32'h1234_5678;
        refill(32'hBFAF_8008, 1'b1, 1, 0, 1, -1);
        checks++; if (o_rdtype !== 3'b010) begin errors++; $display("FAIL uncached_rd_type got=%b exp=010", o_rdtype); end
        checks++; if (o_rdaddr !== 32'hBFAF_8008) begin errors++; $display("FAIL uncached_rd_addr got=%h exp=bfaf8008", o_rdaddr); end
        checks++; if (lv_data[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL uncached_word2 got=%h exp=12345678", lv_data[95:64]); end
        checks++; if (lv_data !== m_line()) begin errors++; $display("FAIL uncached_line got=%h exp=%h", lv_data, m_line()); end
        checks++; if (lv_cnt - lv0 != 1 || lv_cyc != t_last + 1) begin errors++; $display("FAIL uncached_lv got=%0d@%0d exp=1@%0d", lv_cnt - lv0, lv_cyc, t_last + 1); end
    endtask

    task automatic test_cancel_req();
        int lv0;
        lv0 = lv_cnt;
        bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_4440; bus.miss_uncached = 1'b0;
        @(negedge clk);
        bus.miss_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.rd_req !== 1'b1) begin errors++; $display("FAIL cancel_req_held got=%b exp=1", bus.rd_req); end
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL cancel_req_drop got=%b exp=0", bus.rd_req); end
        checks++; if (bus.miss_rdy !== 1'b1) begin errors++; $display("FAIL cancel_req_idle got=%b exp=1", bus.miss_rdy); end
        repeat (4) @(negedge clk);
        checks++; if (lv_cnt != lv0) begin errors++; $display("FAIL cancel_req_no_line got=%0d exp=%0d", lv_cnt, lv0); end
    endtask

    task automatic test_cancel_recv();
        int lv0;
        logic [31:0] a;
        lv0 = lv_cnt;
        for (int i = 0; i < 4; i++) bdata[i] = $urandom;
        refill($urandom, 1'b0, 4, 0, 0, 1);
        checks++; if (lv_cnt != lv0) begin errors++; $display("FAIL cancel_recv_no_line got=%0d exp=%0d", lv_cnt, lv0); end
        checks++; if (o_rdy_n1 !== 1'b1) begin errors++; $display("FAIL cancel_recv_miss_rdy got=%b exp=1", o_rdy_n1); end
        for (int i = 0; i < 4; i++) bdata[i] = $urandom;
        a = $urandom;
        refill(a, 1'b0, 4, 0, 0, -1);
        checks++; if (lv_cnt - lv0 != 1 || lv_data !== m_line()) begin errors++; $display("FAIL cancel_recv_next got=%h exp=%h", lv_data, m_line()); end
        checks++; if (lv_addr !== m_addr(a, 1'b0)) begin errors++; $display("FAIL cancel_recv_next_addr got=%h exp=%h", lv_addr, m_addr(a, 1'b0)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int lv0;
            bit unc;
            logic [31:0] a;
            lv0 = lv_cnt;
            unc = 1'($urandom_range(0, 1));
            a = $urandom;
            for (int i = 0; i < 4; i++) bdata[i] = $urandom;
            refill(a, unc, unc ? 1 : 4, $urandom_range(0, 2), $urandom_range(0, 2), -1);
            checks++; if (o_rdaddr !== m_addr(a, unc) || o_rdtype !== (unc ? 3'b010 : 3'b100)) begin errors++; $display("FAIL rand_req got=%h/%b exp=%h unc=%0d", o_rdaddr, o_rdtype, m_addr(a, unc), unc); end
            checks++; if (lv_cnt - lv0 != 1 || lv_cyc != t_last + 1) begin errors++; $display("FAIL rand_lv got=%0d@%0d exp=1@%0d", lv_cnt - lv0, lv_cyc, t_last + 1); end
            checks++; if (lv_data !== m_line() || lv_addr !== m_addr(a, unc)) begin errors++; $display("FAIL rand_line got=%h/%h exp=%h/%h", lv_data, lv_addr, m_line(), m_addr(a, unc)); end
            checks++; if (bus.proto_err !== m_err) begin errors++; $display("FAIL rand_proto_err got=%b exp=%b", bus.proto_err, m_err); end
        end
    endtask

    task automatic test_proto_err();
        int lv0;
        lv0 = lv_cnt;
        for (int i = 0; i < 4; i++) bdata[i] = $urandom;
        refill($urandom, 1'b0, 3, 0, 0, -1);
        checks++; if (bus.proto_err !== 1'b1 || m_err != 1) begin errors++; $display("FAIL proto_set got=%b exp=1", bus.proto_err); end
        checks++; if (lv_cnt - lv0 != 1 || lv_data !== m_line()) begin errors++; $display("FAIL proto_line got=%h exp=%h", lv_data, m_line()); end
        for (int i = 0; i < 4; i++) bdata[i] = $urandom;
        refill($urandom, 1'b0, 4, 1, 0, -1);
        checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%b exp=1", bus.proto_err); end
    endtask

`ifdef CRITICAL_WORD_FWD_EN
    task automatic test_crit();
        int c0;
        c0 = crit_cnt;
        for (int i = 0; i < 4; i++) bdata[i] = $urandom;
        refill(($urandom & ~32'hF) | 32'h8, 1'b0, 4, 1, 0, -1);
        checks++; if (crit_cnt - c0 != 1) begin errors++; $display("FAIL crit_count got=%0d exp=1", crit_cnt - c0); end
        checks++; if (crit_data !== bdata[2]) begin errors++; $display("FAIL crit_data got=%h exp=%h", crit_data, bdata[2]); end
        checks++; if (crit_cyc != bcyc[2] + 1 || crit_cyc >= lv_cyc) begin errors++; $display("FAIL crit_timing got=%0d exp=%0d lv=%0d", crit_cyc, bcyc[2] + 1, lv_cyc); end
    endtask
`endif

    task automatic test_reset_mid();
        bus.miss_req = 1'b1; bus.miss_addr = $urandom; bus.miss_uncached = 1'b0;
        @(negedge clk);
        bus.miss_req = 1'b0; bus.rd_rdy = 1'b1;
        @(negedge clk);
        bus.rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ret_valid = 1'b1; bus.ret_data = $urandom; bus.ret_last = 1'b0;
            @(negedge clk);
        end
        bus.ret_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.miss_rdy !== 1'b1 || bus.rd_req !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got=%b%b%b exp=100", bus.miss_rdy, bus.rd_req, bus.line_valid); end
        checks++; if (bus.rd_type !== 3'b0 || bus.rd_addr !== 32'h0 || bus.line_addr !== 32'h0) begin errors++; $display("FAIL midreset_addr got=%b/%h/%h exp=0", bus.rd_type, bus.rd_addr, bus.line_addr); end
        checks++; if (bus.line_data !== 128'h0 || bus.proto_err !== 1'b0) begin errors++; $display("FAIL midreset_data got=%h/%b exp=0", bus.line_data, bus.proto_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.miss_uncached = 1'b0; bus.cancel = 1'b0;
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
        @(negedge clk);
        test_reset();
        test_cached_fill();
        test_uncached();
        test_cancel_req();
        test_cancel_recv();
        test_random();
`ifdef CRITICAL_WORD_FWD_EN
        test_crit();
`endif
        test_proto_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
